rf_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the register file's single write port among `NREQ` requesters (e.g. ALU writeback, load return, move unit). It registers the winning request and drives `wr_en`/`wr_addr`/`dat_in` of the register file one cycle after the handshake. Optionally, after reset it runs a clear sequence that zeroes every register before accepting requests. It sits between the datapath writeback sources and the register file.

---
 rtl/rf_wr_arbiter_pkg.sv | 17 +
 rtl/rf_wr_arbiter_if.sv | 28 ++
 rtl/rf_wr_arbiter_rr_arbiter.sv | 29 ++
 rtl/rf_wr_arbiter.sv | 88 ++++++++
 tb/tb_rf_wr_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package rf_pkg;

  localparam int RF_PW = 4;
  localparam int RF_DW = 8;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } rf_arb_state_t;

  typedef struct packed {
    logic [RF_PW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Requester-side handshake and register-file write bus of rf_wr_arbiter.
interface rf_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int PW   = rf_pkg::RF_PW,
  parameter int DW   = rf_pkg::RF_DW
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][PW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    rf_wr_en;
  logic [PW-1:0]           rf_wr_addr;
  logic [DW-1:0]           rf_dat_in;
  logic [IW-1:0]           grant_id;
  logic                    busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_wr_en, rf_wr_addr, rf_dat_in, grant_id, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_wr_en, rf_wr_addr, rf_dat_in, grant_id, busy
  );
endinterface

// File: rtl/rf_wr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, modulo NREQ.
module rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the request closest to ptr is assigned last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin owner of the register-file write port; RF_ARB_CLEAR_EN adds a
// post-reset sequence that zeroes every register before requests are accepted.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = RF_PW,
  parameter int DW   = RF_DW
) (
  input logic          clk,
  input logic          rst_n,
  rf_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  rf_arb_state_t   state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   grant_q;
  logic [NREQ-1:0] gnt;
  logic            wr_en_q;
  logic            xfer;
  rf_wr_t          wr_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is withheld while reset is asserted so req_ready honours its reset value.
  assign bus.req_ready = (rst_n && state == S_RUN) ? gnt : '0;
  assign xfer          = |bus.req_ready;

`ifdef RF_ARB_CLEAR_EN
  localparam rf_arb_state_t RST_STATE = S_CLEAR;
  logic [PW-1:0] clr_addr;
  logic          busy_q;
  assign bus.busy = busy_q;
`else
  localparam rf_arb_state_t RST_STATE = S_RUN;
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      rr_ptr  <= '0;
      wr_en_q <= 1'b0;
      wr_q    <= '0;
      grant_q <= '0;
`ifdef RF_ARB_CLEAR_EN
      clr_addr <= '0;
      busy_q   <= 1'b1;
`endif
    end else begin
`ifdef RF_ARB_CLEAR_EN
      if (state == S_CLEAR) begin
        wr_en_q   <= 1'b1;
        wr_q.addr <= clr_addr;
        wr_q.data <= '0;
        clr_addr  <= clr_addr + 1'b1;
        if (clr_addr == '1) begin
          state  <= S_RUN;
          busy_q <= 1'b0;
        end
      end else
`endif
      begin
        wr_en_q <= xfer;
        if (xfer) begin
          wr_q.addr <= bus.req_addr[gnt_idx];
          wr_q.data <= bus.req_data[gnt_idx];
          grant_q   <= gnt_idx;
          rr_ptr    <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_addr = wr_q.addr;
  assign bus.rf_dat_in  = wr_q.data;
  assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter with a cycle model of the arbitration rules.
module tb_rf_wr_arbiter;
  import rf_pkg::*;

  localparam int NREQ  = 3;
  localparam int PW    = RF_PW;
  localparam int DW    = RF_DW;
  localparam int IW    = $clog2(NREQ);
  localparam int DEPTH = 1 << PW;
`ifdef RF_ARB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rf_wr_arbiter_if #(.NREQ(NREQ), .PW(PW), .DW(DW)) bus ();

  rf_wr_arbiter #(.NREQ(NREQ), .PW(PW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vecs  = 0;
  int fails = 0;

  // model state: cycles since reset release, pointer, expected outputs
  int            mcyc;
  int            mptr;
  logic          m_en;
  logic [PW-1:0] m_addr;
  logic [DW-1:0] m_dat;
  logic [IW-1:0] m_gid;
  logic          m_busy;
  logic [DW-1:0] mrf [DEPTH];
  logic [DW-1:0] orf [DEPTH];
  int            glog [$];
  logic [NREQ-1:0] hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcyc   = 0;
    mptr   = 0;
    m_en   = 1'b0;
    m_addr = '0;
    m_dat  = '0;
    m_gid  = '0;
    m_busy = CLR;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] er;
    int g, idx;
    g  = -1;
    er = '0;
    if (!(CLR && mcyc < DEPTH))
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (g < 0 && bus.req_valid[idx[IW-1:0]]) g = idx;
      end
    if (g >= 0) er[g[IW-1:0]] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    chk("rf_wr_en", bus.rf_wr_en, m_en);
    chk("rf_wr_addr", bus.rf_wr_addr, m_addr);
    chk("rf_dat_in", bus.rf_dat_in, m_dat);
    chk("grant_id", bus.grant_id, m_gid);
    chk("busy", bus.busy, m_busy);
    if (bus.rf_wr_en) orf[bus.rf_wr_addr] = bus.rf_dat_in;
    if (m_en) mrf[m_addr] = m_dat;
    mcyc++;
    if (CLR && mcyc >= 1 && mcyc <= DEPTH) begin
      m_en   = 1'b1;
      m_addr = PW'(mcyc - 1);
      m_dat  = '0;
    end else if (g >= 0) begin
      m_en   = 1'b1;
      m_addr = bus.req_addr[g[IW-1:0]];
      m_dat  = bus.req_data[g[IW-1:0]];
      m_gid  = IW'(g);
      mptr   = (g + 1) % NREQ;
    end else begin
      m_en = 1'b0;
    end
    m_busy = CLR && (mcyc < DEPTH);
  endtask

  task automatic tick(output logic [NREQ-1:0] h);
    @(negedge clk);
    model_step();
    h = bus.req_valid & bus.req_ready;
    for (int i = 0; i < NREQ; i++)
      if (h[i[IW-1:0]]) glog.push_back(i);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rst_wr_en", bus.rf_wr_en, 0);
    chk("rst_wr_addr", bus.rf_wr_addr, 0);
    chk("rst_dat_in", bus.rf_dat_in, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, CLR);
    model_reset();
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_reqs(input int budget, input bit keep);
    logic [NREQ-1:0] h;
    for (int c = 0; c < budget && bus.req_valid != '0; c++) begin
      tick(h);
      if (!keep) bus.req_valid = bus.req_valid & ~h;
    end
    if (keep) bus.req_valid = '0;
    chk("req_timeout", bus.req_valid, 0);
  endtask

  task automatic set_req(input int i, input logic [PW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i[IW-1:0]]  = a;
    bus.req_data[i[IW-1:0]]  = d;
    bus.req_valid[i[IW-1:0]] = 1'b1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      orf[i[PW-1:0]] = 8'hFF;
      mrf[i[PW-1:0]] = 8'hFF;
    end
    model_reset();
    #3;

`ifdef RF_ARB_CLEAR_EN
    // interrupt the clear at address 7, then let it restart
    reset_assert();
    reset_release();
    chk("clr_c0_en", bus.rf_wr_en, 0);
    repeat (8) tick(hs);
    chk("clr_mid_addr", bus.rf_wr_addr, 7);
    chk("clr_mid_busy", bus.busy, 1);
`endif

    reset_assert();
    set_req(0, 4'd9, 8'h5A);
    reset_release();

`ifdef RF_ARB_CLEAR_EN
    tick(hs);
    chk("clr_restart_en", bus.rf_wr_en, 1);
    chk("clr_restart_addr", bus.rf_wr_addr, 0);
    repeat (DEPTH - 1) tick(hs);
    chk("clr_end_ready", bus.req_ready, 3'b001);
    chk("clr_end_busy", bus.busy, 0);
    chk("clr_last_addr", bus.rf_wr_addr, 15);
    tick(hs);
    bus.req_valid = bus.req_valid & ~hs;
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_rf_zero", orf[i[PW-1:0]], 0);
      chk("clr_model_zero", mrf[i[PW-1:0]], 0);
    end
`else
    #1;
    chk("first_ready", bus.req_ready, 3'b001);
    chk("first_busy", bus.busy, 0);
    tick(hs);
    bus.req_valid = bus.req_valid & ~hs;
`endif
    chk("first_wr_en", bus.rf_wr_en, 1);
    chk("first_wr_addr", bus.rf_wr_addr, 9);
    chk("first_dat", bus.rf_dat_in, 8'h5A);
    tick(hs);

    // requester 1 alone writes 0xA5 to r3
    set_req(1, 4'd3, 8'hA5);
    #1;
    chk("r1_ready", bus.req_ready, 3'b010);
    tick(hs);
    bus.req_valid = bus.req_valid & ~hs;
    chk("r1_wr_en", bus.rf_wr_en, 1);
    chk("r1_wr_addr", bus.rf_wr_addr, 3);
    chk("r1_dat", bus.rf_dat_in, 8'hA5);
    chk("r1_gid", bus.grant_id, 1);
    tick(hs);
    chk("r3_value", orf[3], 8'hA5);

    // same-address collision with pointer at 2
    glog.delete();
    set_req(0, 4'd5, 8'h11);
    set_req(2, 4'd5, 8'h22);
    run_reqs(6, 1'b0);
    tick(hs);
    chk("coll_len", glog.size(), 2);
    chk("coll_first", glog[0], 2);
    chk("coll_second", glog[1], 0);
    chk("r5_value", orf[5], 8'h11);
    chk("r5_model", mrf[5], 8'h11);

    // requester 2 alone moves the pointer back to 0
    set_req(2, 4'd7, 8'h77);
    run_reqs(NREQ + 1, 1'b0);
    tick(hs);
    chk("r7_value", orf[7], 8'h77);

    // all valid for six cycles
    glog.delete();
    set_req(0, 4'd10, 8'h30);
    set_req(1, 4'd11, 8'h31);
    set_req(2, 4'd12, 8'h32);
    run_reqs(6, 1'b1);
    tick(hs);
    chk("fair_len", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk("fair_order", glog[i], i % NREQ);
    chk("r11_value", orf[11], 8'h31);

    // reset while a registered write is on the port
    set_req(0, 4'd1, 8'hEE);
    tick(hs);
    chk("mw_wr_en", bus.rf_wr_en, 1);
    reset_assert();
    reset_release();
    chk("mw_post_en", bus.rf_wr_en, 0);
    chk("mw_post_busy", bus.busy, CLR);
    repeat (DEPTH + 2) tick(hs);
    chk("mw_r1_not_ee", (orf[1] == 8'hEE), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
